icache_line_fill: RTL

//  Memory-side responder for ICACHE line misses. It accepts a miss address and

---
 rtl/icache_line_fill.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/icache_line_fill.sv
// icache_line_fill
// Memory-side responder for ICACHE line misses. One accepted miss turns into
// eight in-order word reads starting at the 32-byte-aligned base address. The
// words are assembled into a private line buffer, and that buffer is copied to
// block_read_fIC in one step when the fill completes. The copy happens together
// with a one-cycle block_read_valid pulse. ICACHE therefore never sees a
// partially filled line.
module icache_line_fill #(
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W         = 32
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         fill_req,
  input  logic [ADDR_W-1:0]            fill_addr,
  output logic                         mem_rd,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [31:0]                  mem_rdata,
  input  logic                         mem_ack,
  output logic [32*WORDS_PER_LINE-1:0] block_read_fIC,
  output logic                         block_read_valid,
  output logic                         busy
);

  localparam int LINE_W = 32 * WORDS_PER_LINE;
  localparam int CNT_W  = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = CNT_W + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                r_mem_rd;
  logic                w_mem_rd_nxt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [LINE_W-1:0]   r_line;
  logic [LINE_W-1:0]   w_line_nxt;
  logic [LINE_W-1:0]   r_block;
  logic [LINE_W-1:0]   w_block_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic [CNT_W+4:0]    w_bitpos;
  logic                w_unused_addr_bits;

  // Offset bits inside the line never matter: fills always start at word 0.
  assign w_unused_addr_bits = ^fill_addr[OFF_W-1:0];

  assign mem_rd           = r_mem_rd;
  assign mem_addr         = r_mem_addr;
  assign block_read_fIC   = r_block;
  assign block_read_valid = r_valid;
  assign busy             = r_busy;

  // FSM state register; reset abandons any fill in progress.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic. Word 0 lands in the top 32 bits so that
  // ICACHE offset extraction counts down from bit 255.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_mem_rd_nxt   = r_mem_rd;
    w_mem_addr_nxt = r_mem_addr;
    w_line_nxt     = r_line;
    w_block_nxt    = r_block;
    w_valid_nxt    = 1'b0;
    w_busy_nxt     = r_busy;
    w_cnt_inc      = r_cnt + CNT_W'(1'b1);
    w_bitpos       = {(LAST_CNT - r_cnt), 5'd0};
    case (r_state)
      ST_IDLE: begin
        if (fill_req) begin
          w_state_nxt    = ST_READ;
          w_cnt_nxt      = {CNT_W{1'b0}};
          w_mem_rd_nxt   = 1'b1;
          w_mem_addr_nxt = {fill_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          w_busy_nxt     = 1'b1;
        end else begin
          w_mem_rd_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
      end
      ST_READ: begin
        if (mem_ack && r_mem_rd) begin
          w_line_nxt[w_bitpos +: 32] = mem_rdata;
          if (r_cnt == LAST_CNT) begin
            w_state_nxt  = ST_DONE;
            w_mem_rd_nxt = 1'b0;
            w_block_nxt  = w_line_nxt;
            w_valid_nxt  = 1'b1;
          end else begin
            // The base bits above the line offset stay fixed, so the
            // address cannot carry past bit 31 at the top of memory.
            w_cnt_nxt      = w_cnt_inc;
            w_mem_addr_nxt = {r_mem_addr[ADDR_W-1:OFF_W], w_cnt_inc, 2'b00};
          end
        end else begin
          w_mem_rd_nxt   = r_mem_rd;
          w_mem_addr_nxt = r_mem_addr;
        end
      end
      ST_DONE: begin
        w_state_nxt  = ST_IDLE;
        w_mem_rd_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_cnt_nxt    = {CNT_W{1'b0}};
        w_mem_rd_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset clears every output, the valid pulse included.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt      <= {CNT_W{1'b0}};
      r_mem_rd   <= 1'b0;
      r_mem_addr <= {ADDR_W{1'b0}};
      r_line     <= {LINE_W{1'b0}};
      r_block    <= {LINE_W{1'b0}};
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_mem_rd   <= w_mem_rd_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_line     <= w_line_nxt;
      r_block    <= w_block_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

endmodule
